// File: rtl/debounce_pkg.sv
// debounce_pkg: shared widths, default debounce length and per-bit FSM encoding
package debounce_pkg;
   localparam int SW_WIDTH = 10;
   localparam int KEY_WIDTH = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, stability counter and two-state FSM for one raw input bit
//   clk, rst : system clock, asynchronous active-high reset
//   din      : raw asynchronous input
//   level    : debounced level (resets to RESET_VALUE)
//   pulse    : one-cycle pulse on any accepted change (ANY_EDGE=1) or only on a change away from RESET_VALUE
module debounce_bit import debounce_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_VALUE = 1'b0,
   parameter bit ANY_EDGE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic s;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic level_n, pulse_n;
   assign s = sync[SYNC_STAGES-1];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= {SYNC_STAGES{RESET_VALUE}};
         state <= STABLE;
         cnt <= '0;
         level <= RESET_VALUE;
         pulse <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         state <= state_n;
         cnt <= cnt_n;
         level <= level_n;
         pulse <= pulse_n;
      end
   // The count includes the cycle that enters PENDING, so the D-th differing sample flips the level.
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      level_n = level;
      pulse_n = 1'b0;
      if (s == level) begin
         state_n = STABLE;
         cnt_n = '0;
      end else if (state == STABLE) begin
         state_n = PENDING;
         cnt_n = CW'(1);
      end else if (cnt == LAST) begin
         state_n = STABLE;
         cnt_n = '0;
         level_n = s;
         pulse_n = ANY_EDGE || (s != RESET_VALUE);
      end else
         cnt_n = cnt + 1'b1;
   end
endmodule

// File: rtl/input_debounce.sv
// input_debounce: debounces 10 slide switches and 2 active-low push buttons
//   CLK, RST   : system clock, asynchronous active-high reset
//   SW_IN      : raw switches (active-high)      -> SW_OUT debounced levels, SW_CHANGED any-bit change pulse
//   KEY_IN     : raw buttons (active-low)        -> KEY_LEVEL pressed state, KEY_PRESS press pulse
module input_debounce import debounce_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic [SW_WIDTH-1:0] SW_IN,
   input  logic [KEY_WIDTH-1:0] KEY_IN,
   output logic [SW_WIDTH-1:0] SW_OUT,
   output logic [KEY_WIDTH-1:0] KEY_LEVEL,
   output logic [KEY_WIDTH-1:0] KEY_PRESS,
   output logic SW_CHANGED
);
   logic [SW_WIDTH-1:0] sw_chg;
   logic [KEY_WIDTH-1:0] key_raw;
   for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0), .ANY_EDGE(1'b1)) u_bit (
         .clk(CLK), .rst(RST), .din(SW_IN[i]), .level(SW_OUT[i]), .pulse(sw_chg[i]));
   end
   // Buttons are debounced in raw polarity; a press is the raw level leaving its released value.
   for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1), .ANY_EDGE(1'b0)) u_bit (
         .clk(CLK), .rst(RST), .din(KEY_IN[i]), .level(key_raw[i]), .pulse(KEY_PRESS[i]));
   end
   assign KEY_LEVEL = ~key_raw;
   assign SW_CHANGED = |sw_chg;
endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth per input bit; legal range 2..3.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SW_IN  input  10  raw slide switches, asynchronous to CLK, active-high.
REQ-006 SHALL have port KEY_IN  input  2  raw push buttons, asynchronous to CLK, active-low (0 = pressed).
REQ-007 SHALL have port SW_OUT  output  10  debounced switch levels, active-high; feeds the downstream majority/display logic SW input.
REQ-008 SHALL have port KEY_LEVEL  output  2  debounced button state, active-high (1 = pressed).
REQ-009 SHALL have port KEY_PRESS  output  2  one-cycle pulse on each accepted press (released -> pressed).
REQ-010 SHALL have port SW_CHANGED  output  1  one-cycle pulse when any SW_OUT bit changes.

Function
REQ-011 SHALL pass each of the 12 input bits through a SYNC_STAGES flip-flop chain before any other logic uses it.
REQ-012 SHALL keep one stable-state register and one counter per bit, with the counter wide enough for DEBOUNCE_CYCLES-1.
REQ-013 SHALL implement a per-bit FSM with two states: STABLE (synchronized input equals stable state; counter held at 0) and PENDING (input differs; counter increments by 1 each cycle).
REQ-014 SHALL return from PENDING to STABLE with the counter cleared to 0 and the stable state unchanged when the synchronized input reverts before the count completes (bounce rejection).
REQ-015 SHALL flip the stable state, clear the counter and enter STABLE on the cycle in which the counter equals DEBOUNCE_CYCLES-1 and the input still differs.
REQ-016 SHALL give a clean level change held on the raw pin a latency of exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges to the outputs.
REQ-017 SHALL assert KEY_PRESS[i] for exactly one cycle, coincident with KEY_LEVEL[i] rising, and SHALL produce no pulse on release.
REQ-018 SHALL assert SW_CHANGED for one cycle when one or more SW bits flip on the same edge, including simultaneous flips.
REQ-019 SHALL debounce all bits independently; a bounce on one bit SHALL NOT affect the counters of other bits.
REQ-020 SHALL not allow counters to wrap; PENDING always resolves at DEBOUNCE_CYCLES-1.
REQ-021 SHALL drive all outputs directly from registers, with no combinational path from any input to any output.

Reset
REQ-022 SHALL, while RST=1, immediately and independently of CLK force: SW sync flops, SW stable state and SW_OUT to 0; KEY sync flops to 1 (released); KEY_LEVEL, KEY_PRESS and SW_CHANGED to 0; all counters to 0; all FSMs to STABLE.
REQ-023 SHALL discard any pending count when reset is asserted mid-operation; after release, a held input SHALL require the full REQ-016 latency again.
REQ-024 SHALL produce no KEY_PRESS or SW_CHANGED pulse caused merely by reset deassertion when the inputs equal their reset values.

Structure
REQ-025 SHALL place the following in shared package debounce_pkg: SW_WIDTH=10, KEY_WIDTH=2, DEFAULT_DEBOUNCE_CYCLES=500000, and the FSM state encoding (STABLE=0, PENDING=1).
REQ-026 SHALL instantiate one sub-module, debounce_bit (synchronizer, counter, FSM, rise/change pulse), 12 times with a RESET_VALUE parameter (0 for SW, 1 for KEY).
REQ-027 SHALL keep the top level limited to instantiation, KEY inversion and the OR-reduction for SW_CHANGED.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-028 SHALL cover: RST=1 with SW_IN=10'h3FF and KEY_IN=2'b00 -> SW_OUT=0, KEY_LEVEL=0, no pulses, asynchronously before any CLK edge.
REQ-029 SHALL cover: SW_IN[2:0] 000->101 held -> SW_OUT[2:0]=101 exactly 6 edges later and SW_CHANGED=1 for that single cycle.
REQ-030 SHALL cover: SW_IN[0] toggled every 2 cycles for 20 cycles, then held at 0 -> SW_OUT[0] stays 0 throughout.
REQ-031 SHALL cover: KEY_IN[1] 1->0 held 10 cycles, then 0->1 -> KEY_PRESS[1] pulses once 6 edges after press with KEY_LEVEL[1]=1, and no pulse on release.
REQ-032 SHALL cover: SW_IN[5] 0->1 with RST pulsed at edge 3 -> SW_OUT[5]=0 through reset, and becomes 1 exactly 6 edges after RST deassertion.
REQ-033 SHALL cover: all 8 values of SW_IN[2:0], each held 10 cycles -> SW_OUT[2:0] follows each value with 6-edge latency and the downstream majority output matches the truth table.
